detector_stream_scheduler: RTL

- Shares one bit-serial 1101 sequence detector between NREQ word-parallel requesters.
- Round-robin arbitrates among the requesters and serializes the granted word MSB-first into the detector.
- Clears the detector before each word so that words are independent.
- Counts detector match pulses and returns the count with the requester ID over a valid/ready response port.
- Sits between the requester fabric and the detector instance; the detector connects through the det_* ports.

---
 rtl/detector_ctrl_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 48 ++++
 rtl/detector_stream_scheduler.sv | 120 ++++++++++++
 3 files changed

// File: rtl/detector_ctrl_pkg.sv
// Shared state encoding and default sizing for the detector stream scheduler.
package detector_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SHIFT,
        DRAIN,
        DONE
    } state_t;

    localparam int DET_LAT_DEFAULT = 2;
    localparam int W_DEFAULT       = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last accepted requester.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] i_req,
    input  logic            i_enable,
    input  logic            i_advance,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_index
);

    logic [IDW-1:0] r_ptr;
    logic           w_found;

    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return IDW'(s);
    endfunction

    // NOTE: every variable written here gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        w_found = 1'b0;
        o_index = '0;
        o_grant = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && i_req[wrap_add(r_ptr, i)]) begin
                w_found = 1'b1;
                o_index = wrap_add(r_ptr, i);
            end
        end
        if (i_enable && w_found) o_grant[o_index] = 1'b1;
    end

    // r_ptr is the next search start; it moves only when a grant is actually taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            r_ptr <= wrap_add(o_index, 1);
        end
    end

endmodule

// File: rtl/detector_stream_scheduler.sv
// Shares one bit-serial 1101 detector among NREQ requesters: arbitrate, clear the
// detector, shift the word MSB-first, count match pulses, return (id, count).
module detector_stream_scheduler
    import detector_ctrl_pkg::*;
#(
    parameter int W       = W_DEFAULT,
    parameter int NREQ    = 2,
    parameter int DET_LAT = DET_LAT_DEFAULT,
    parameter int CW      = $clog2(W + 1),
    parameter int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [CW-1:0]     rsp_count,
    output logic              busy,
    output logic              det_x,
    output logic              det_rst,
    input  logic              det_y
);

    localparam int KW = $clog2(W + DET_LAT + 1);

    state_t          r_state;
    state_t          w_next;
    logic [W-1:0]    r_shreg;
    logic [KW-1:0]   r_k;
    logic [CW-1:0]   r_count;
    logic [IDW-1:0]  r_id;
    logic            r_det_x;
    logic            r_det_rst;
    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_gidx;
    logic            w_enable;
    logic            w_accept;
    logic            w_sample;

    // Grants are suppressed while reset is asserted even though the state already reads IDLE.
    assign w_enable = (r_state == IDLE) && !reset;
    assign w_accept = |w_grant;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arbiter (
        .clk       (clk),
        .reset     (reset),
        .i_req     (req_valid),
        .i_enable  (w_enable),
        .i_advance (w_accept),
        .o_grant   (w_grant),
        .o_index   (w_gidx)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = CLEAR;
            CLEAR:   w_next = SHIFT;
            SHIFT:   if (r_k == KW'(W - 1)) w_next = DRAIN;
            DRAIN:   if (r_k == KW'(DET_LAT - 1)) w_next = DONE;
            DONE:    if (rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Early SHIFT pulses belong to the cleared detector; the last DET_LAT bits land in DRAIN.
    assign w_sample = ((r_state == SHIFT) && (r_k >= KW'(DET_LAT))) || (r_state == DRAIN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shreg   <= '0;
            r_k       <= '0;
            r_count   <= '0;
            r_id      <= '0;
            r_det_x   <= 1'b0;
            r_det_rst <= 1'b1;
        end else begin
            // Detector controls are registered from the next state so they align with it.
            r_det_rst <= (w_next == CLEAR);
            r_det_x   <= (w_next == SHIFT) ? r_shreg[W-1] : 1'b0;

            if (r_state != w_next) begin
                r_k <= '0;
            end else if ((r_state == SHIFT) || (r_state == DRAIN)) begin
                r_k <= r_k + KW'(1);
            end

            if (w_accept) begin
                r_shreg <= req_data[int'(w_gidx)*W +: W];
                r_id    <= w_gidx;
                r_count <= '0;
            end else if (w_next == SHIFT) begin
                r_shreg <= {r_shreg[W-2:0], 1'b0};
            end

            if (w_sample) r_count <= r_count + CW'(det_y);
        end
    end

    assign req_ready = w_grant;
    assign rsp_valid = (r_state == DONE);
    assign rsp_id    = r_id;
    assign rsp_count = r_count;
    assign busy      = (r_state != IDLE);
    assign det_x     = r_det_x;
    assign det_rst   = r_det_rst;

endmodule
